// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR on WIDTH-bit operands, SLICE bits per
// cycle (LSB slice first), start/ready handshake and a registered zero flag on the result.
module sliced_logic_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_start,
   input  logic [1:0]       ctrl_ALUopcode,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_isZero,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned N     = WIDTH / SLICE;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_next;
   logic [CNT_W-1:0] cnt_q;

   function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       op,
                                                 input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b);
      logic [SLICE-1:0] r;
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~(a | b);
      endcase
      return r;
   endfunction

   // Accumulator with the current slice filled in; other slices pass through untouched.
   always_comb begin
      acc_next = acc_q;
      for (int s = 0; s < int'(N); s++) begin
         if (cnt_q == CNT_W'(s)) begin
            acc_next[s*SLICE +: SLICE] = slice_op(op_q, a_q[s*SLICE +: SLICE],
                                                  b_q[s*SLICE +: SLICE]);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt_q          <= '0;
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         acc_q          <= '0;
         data_result    <= '0;
         data_isZero    <= 1'b1;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (ctrl_start) begin
                  a_q   <= data_operandA;
                  b_q   <= data_operandB;
                  op_q  <= ctrl_ALUopcode;
                  acc_q <= '0;
                  cnt_q <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc_q <= acc_next;
               if (cnt_q == LAST) begin
                  // Final slice: publish the whole word at once so partials never show.
                  cnt_q          <= '0;
                  data_result    <= acc_next;
                  data_isZero    <= (acc_next == '0);
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  state          <= DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (ctrl_start) begin
                  a_q   <= data_operandA;
                  b_q   <= data_operandB;
                  op_q  <= ctrl_ALUopcode;
                  acc_q <= '0;
                  cnt_q <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Self-checking bench for sliced_logic_unit: directed table, handshake corner cases,
// randomized operations against a whole-word reference, and two alternate geometries.
module tb_sliced_logic_unit;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;

   logic        start32;
   logic [1:0]  op32;
   logic [31:0] a32, b32, res32;
   logic        z32, rdy32, busy32;

   logic        start16;
   logic [1:0]  op16;
   logic [15:0] a16, b16, res16;
   logic        z16, rdy16, busy16;

   logic        start64;
   logic [1:0]  op64;
   logic [63:0] a64, b64, res64;
   logic        z64, rdy64, busy64;

   sliced_logic_unit #(.WIDTH(32), .SLICE(8)) dut32 (
      .clock(clock), .reset(reset), .ctrl_start(start32), .ctrl_ALUopcode(op32),
      .data_operandA(a32), .data_operandB(b32), .data_result(res32),
      .data_isZero(z32), .data_resultRDY(rdy32), .busy(busy32));

   sliced_logic_unit #(.WIDTH(16), .SLICE(16)) dut16 (
      .clock(clock), .reset(reset), .ctrl_start(start16), .ctrl_ALUopcode(op16),
      .data_operandA(a16), .data_operandB(b16), .data_result(res16),
      .data_isZero(z16), .data_resultRDY(rdy16), .busy(busy16));

   sliced_logic_unit #(.WIDTH(64), .SLICE(4)) dut64 (
      .clock(clock), .reset(reset), .ctrl_start(start64), .ctrl_ALUopcode(op64),
      .data_operandA(a64), .data_operandB(b64), .data_result(res64),
      .data_isZero(z64), .data_resultRDY(rdy64), .busy(busy64));

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] exp;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Whole-word reference: the slicing must be invisible in the final answer.
   function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // One operation on the 32/8 unit, checking latency, busy length, result, flag and pulse width.
   task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp, input logic exp_zero);
      int lat;
      int busy_cnt;
      bit seen;
      a32 = a; b32 = b; op32 = op; start32 = 1'b1;
      tick();
      start32 = 1'b0;
      a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
      lat = 0; busy_cnt = 0; seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (busy32) busy_cnt++;
         tick();
         lat++;
         if (rdy32) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, " rdy_seen"}, 64'(seen), 64'd1);
      check({name, " latency"}, 64'(lat), 64'd4);
      check({name, " busy_cycles"}, 64'(busy_cnt), 64'd4);
      check({name, " busy_at_rdy"}, 64'(busy32), 64'd0);
      check({name, " result"}, 64'(res32), 64'(exp));
      check({name, " is_zero"}, 64'(z32), 64'(exp_zero));
      tick();
      check({name, " rdy_one_cycle"}, 64'(rdy32), 64'd0);
      check({name, " result_hold"}, 64'(res32), 64'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] e1, e2, ra, rb, re;
      logic [1:0]  rop;
      logic [63:0] ea;
      int lat, pulses;

      vecs[0] = '{32'h0000_0009, 32'h0000_000C, 2'b01, 32'h0000_000D, 1'b0};
      vecs[1] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 2'b00, 32'h0F0F_0000, 1'b0};
      vecs[2] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 2'b10, 32'hF0F0_0F0F, 1'b0};
      vecs[3] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 2'b11, 32'h0000_F0F0, 1'b0};
      vecs[4] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b10, 32'h0000_0000, 1'b1};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 1'b0};

      start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      start64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
      reset = 1'b1;
      tick();
      tick();
      check("reset result", 64'(res32), 64'd0);
      check("reset is_zero", 64'(z32), 64'd1);
      check("reset rdy", 64'(rdy32), 64'd0);
      check("reset busy", 64'(busy32), 64'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run32($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
               vecs[i].exp, vecs[i].exp_zero);
      end

      // Start held through BUSY with changing operands; DONE with start chains immediately.
      a32 = 32'h1234_5678; b32 = 32'h0F0F_0000; op32 = 2'b10; start32 = 1'b1;
      e1 = 32'(ref_op(2'b10, 64'(32'h1234_5678), 64'(32'h0F0F_0000)));
      tick();
      a32 = 32'hDEAD_BEEF; b32 = 32'h00FF_00FF; op32 = 2'b00;
      e2 = 32'(ref_op(2'b00, 64'(32'hDEAD_BEEF), 64'(32'h00FF_00FF)));
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rdy32) pulses++;
      end
      check("b2b no_early_rdy", 64'(pulses), 64'd0);
      tick();
      check("b2b first_rdy", 64'(rdy32), 64'd1);
      check("b2b first_result", 64'(res32), 64'(e1));
      tick();
      check("b2b no_bubble_busy", 64'(busy32), 64'd1);
      check("b2b rdy_dropped", 64'(rdy32), 64'd0);
      start32 = 1'b0;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         lat++;
         if (rdy32) break;
      end
      check("b2b second_latency", 64'(lat), 64'd4);
      check("b2b second_rdy", 64'(rdy32), 64'd1);
      check("b2b second_result", 64'(res32), 64'(e2));
      tick();

      // Reset two cycles into BUSY aborts the operation.
      a32 = 32'hFFFF_FFFF; b32 = 32'h0; op32 = 2'b01; start32 = 1'b1;
      tick();
      start32 = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort result", 64'(res32), 64'd0);
      check("abort is_zero", 64'(z32), 64'd1);
      check("abort busy", 64'(busy32), 64'd0);
      check("abort rdy", 64'(rdy32), 64'd0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rdy32 || busy32) pulses++;
      end
      check("abort no_pulse", 64'(pulses), 64'd0);
      run32("after_abort", 32'h0000_00F0, 32'h0000_0F00, 2'b01, 32'h0000_0FF0, 1'b0);

      // Randomized operations against the whole-word reference.
      for (int i = 0; i < 30; i++) begin
         ra = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3));
         if (i % 7 == 0) begin
            rb = ra;
            rop = 2'b10;
         end
         re = 32'(ref_op(rop, 64'(ra), 64'(rb)));
         run32($sformatf("rand%0d", i), ra, rb, rop, re, re == 32'h0);
      end

      // Single-slice geometry: BUSY lasts one cycle.
      a16 = 16'h0001; b16 = 16'h8000; op16 = 2'b01; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      check("w16 busy_after_start", 64'(busy16), 64'd1);
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         lat++;
         if (rdy16) break;
      end
      check("w16 latency", 64'(lat), 64'd1);
      check("w16 rdy", 64'(rdy16), 64'd1);
      check("w16 result", 64'(res16), 64'h8001);
      check("w16 is_zero", 64'(z16), 64'd0);
      tick();

      // Sixteen 4-bit slices.
      a64 = 64'h1; b64 = 64'h8000_0000_0000_0000; op64 = 2'b01; start64 = 1'b1;
      tick();
      start64 = 1'b0;
      a64 = '0; b64 = '0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         lat++;
         if (rdy64) break;
      end
      check("w64 latency", 64'(lat), 64'd16);
      check("w64 rdy", 64'(rdy64), 64'd1);
      check("w64 result", res64, 64'h8000_0000_0000_0001);
      check("w64 is_zero", 64'(z64), 64'd0);
      tick();

      for (int i = 0; i < 4; i++) begin
         a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
         op64 = 2'($urandom_range(0, 3));
         ea = ref_op(op64, a64, b64);
         start64 = 1'b1;
         tick();
         start64 = 1'b0;
         lat = 0;
         for (int j = 0; j < 40; j++) begin
            tick();
            lat++;
            if (rdy64) break;
         end
         check($sformatf("w64 rand%0d latency", i), 64'(lat), 64'd16);
         check($sformatf("w64 rand%0d result", i), res64, ea);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
